// File: rtl/mult_req_arbiter_if.sv
// Channel bundle between mult_req_arbiter, its two requesters and the shared
// online multiplier core; master is the arbiter side, slave the environment side.
interface mult_req_arbiter_if;
  logic [1:0] req_vld;
  logic [1:0] req_rdy;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic [1:0] req_last;
  logic       mult_x_vld;
  logic       mult_x_rdy;
  logic       mult_y_vld;
  logic       mult_y_rdy;
  logic [1:0] mult_x_value;
  logic [1:0] mult_y_value;
  logic       mult_out_vld;
  logic       mult_out_rdy;
  logic [1:0] mult_z_value;
  logic [1:0] rsp_vld;
  logic [1:0] rsp_rdy;
  logic [1:0] rsp_z;
  logic       grant_id;
  logic       busy;

  modport master (
    input  req_vld, req_x, req_y, req_last,
    input  mult_x_rdy, mult_y_rdy, mult_out_vld, mult_z_value, rsp_rdy,
    output req_rdy, mult_x_vld, mult_y_vld, mult_x_value, mult_y_value,
    output mult_out_rdy, rsp_vld, rsp_z, grant_id, busy
  );

  modport slave (
    output req_vld, req_x, req_y, req_last,
    output mult_x_rdy, mult_y_rdy, mult_out_vld, mult_z_value, rsp_rdy,
    input  req_rdy, mult_x_vld, mult_y_vld, mult_x_value, mult_y_value,
    input  mult_out_rdy, rsp_vld, rsp_z, grant_id, busy
  );
endinterface

// File: rtl/mult_req_arbiter.sv
// Operand-granular arbiter sharing one digit-serial multiplier between two requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 wins ties.
module mult_req_arbiter #(
  parameter int OUT_CNT_WIDTH = 4
) (
  input logic                clk,
  input logic                asyn_reset_n,
  mult_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [OUT_CNT_WIDTH-1:0] MAX_OUT  = {OUT_CNT_WIDTH{1'b1}};
  localparam logic [OUT_CNT_WIDTH-1:0] CNT_ZERO = {OUT_CNT_WIDTH{1'b0}};
  localparam logic [OUT_CNT_WIDTH-1:0] CNT_ONE  = {{(OUT_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [OUT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     x_done_q, x_done_d;
  logic                     y_done_q, y_done_d;
  logic                     grant_q, grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                     ptr_q, ptr_d;
`endif

  logic       sel_vld_s;
  logic       sel_last_s;
  logic [1:0] sel_x_s;
  logic [1:0] sel_y_s;
  logic       sel_rsp_rdy_s;
  logic       issue_en_s;
  logic       ret_en_s;
  logic       cnt_ok_s;
  logic       x_vld_s;
  logic       y_vld_s;
  logic       x_hs_s;
  logic       y_hs_s;
  logic       pair_done_s;
  logic       z_hs_s;
  logic       winner_s;
  logic [1:0] grant_oh_s;

  // Route the granted requester's channel onto internal selects
  always_comb begin
    if (grant_q) begin
      sel_vld_s     = bus.req_vld[1];
      sel_last_s    = bus.req_last[1];
      sel_x_s       = bus.req_x[3:2];
      sel_y_s       = bus.req_y[3:2];
      sel_rsp_rdy_s = bus.rsp_rdy[1];
      grant_oh_s    = 2'b10;
    end else begin
      sel_vld_s     = bus.req_vld[0];
      sel_last_s    = bus.req_last[0];
      sel_x_s       = bus.req_x[1:0];
      sel_y_s       = bus.req_y[1:0];
      sel_rsp_rdy_s = bus.rsp_rdy[0];
      grant_oh_s    = 2'b01;
    end
  end

  // Issue/return handshake qualification; x and y may be accepted in different cycles
  always_comb begin
    issue_en_s  = (state_q == ST_ISSUE);
    ret_en_s    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    cnt_ok_s    = (cnt_q != MAX_OUT);
    x_vld_s     = issue_en_s & sel_vld_s & ~x_done_q & cnt_ok_s;
    y_vld_s     = issue_en_s & sel_vld_s & ~y_done_q & cnt_ok_s;
    x_hs_s      = x_vld_s & bus.mult_x_rdy;
    y_hs_s      = y_vld_s & bus.mult_y_rdy;
    pair_done_s = issue_en_s & (x_done_q | x_hs_s) & (y_done_q | y_hs_s);
    z_hs_s      = ret_en_s & bus.mult_out_vld & sel_rsp_rdy_s;
  end

  // Tie-break among requesters seen in IDLE
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.req_vld == 2'b11) begin
      winner_s = ptr_q;
    end else begin
      winner_s = ~bus.req_vld[0];
    end
`else
    winner_s = ~bus.req_vld[0];
`endif
  end

  // Next-state logic: FSM, pair flags and outstanding-digit counter
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    x_done_d = x_done_q;
    y_done_d = y_done_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif

    case ({pair_done_s, z_hs_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if (pair_done_s) begin
      x_done_d = 1'b0;
      y_done_d = 1'b0;
    end else begin
      x_done_d = x_done_q | x_hs_s;
      y_done_d = y_done_q | y_hs_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (|bus.req_vld) begin
          grant_d = winner_s;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (pair_done_s && sel_last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = ~grant_q;
`endif
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight digits
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      x_done_q <= 1'b0;
      y_done_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_done_q <= x_done_d;
      y_done_q <= y_done_d;
      grant_q  <= grant_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer, moves to the loser when an operand retires
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Output decode; non-granted requester lanes stay at zero
  always_comb begin
    bus.req_rdy      = pair_done_s ? grant_oh_s : 2'b00;
    bus.rsp_vld      = (ret_en_s & bus.mult_out_vld) ? grant_oh_s : 2'b00;
    bus.mult_x_vld   = x_vld_s;
    bus.mult_y_vld   = y_vld_s;
    bus.mult_x_value = issue_en_s ? sel_x_s : 2'b00;
    bus.mult_y_value = issue_en_s ? sel_y_s : 2'b00;
    bus.mult_out_rdy = ret_en_s & sel_rsp_rdy_s;
    bus.rsp_z        = ret_en_s ? bus.mult_z_value : 2'b00;
    bus.grant_id     = grant_q;
    bus.busy         = (state_q != ST_IDLE);
  end

endmodule
